// File: rtl/elev_pkg.sv
// Shared types and default sizing for the elevator car controller.
package elev_pkg;

    localparam int DEF_FLOORS     = 4;
    localparam int DEF_DOOR_TICKS = 3;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

endpackage

// File: rtl/tick_sync.sv
// Brings a slow asynchronous clock-like signal into the clk domain and emits a
// one-cycle pulse for each of its rising edges.
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Reset high: an input already high at release must not look like a rising edge.
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            tick  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments give every flop its old neighbour's value,
            // which is what makes this a shift chain rather than a single wire.
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
            tick  <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator car controller: latches floor requests, steps one floor per
// divided-clock tick and holds the door open for a fixed number of ticks.
module elevator_ctrl
    import elev_pkg::*;
#(
    parameter  int FLOORS     = DEF_FLOORS,
    parameter  int DOOR_TICKS = DEF_DOOR_TICKS,
    localparam int FW         = $clog2(FLOORS)
) (
    input  logic              clk100mhz,
    input  logic              rst,
    input  logic              clk3hz,
    input  logic [FLOORS-1:0] req_btn,
    output logic [FW-1:0]     floor,
    output logic              moving_up,
    output logic              moving_down,
    output logic              door_open,
    output logic [FLOORS-1:0] req_pending
);

    localparam int CW = $clog2(DOOR_TICKS + 1);

    state_t            state;
    logic              dir;
    logic [FLOORS-1:0] req;
    logic [CW-1:0]     door_cnt;
    logic              tick;

    logic              above;
    logic              below;
    logic              here;
    logic              go_up;
    logic              go_down;
    logic [FW-1:0]     floor_up;
    logic [FW-1:0]     floor_dn;
    logic [FLOORS-1:0] req_set;
    logic [FLOORS-1:0] req_clr;

    tick_sync u_tick_sync (
        .clk      (clk100mhz),
        .rst      (rst),
        .async_in (clk3hz),
        .tick     (tick)
    );

    assign floor_up = floor + 1'b1;
    assign floor_dn = floor - 1'b1;

    always_comb begin
        // NOTE: every variable gets a value before any conditional code, so no
        // path through the block can leave it unassigned and infer a latch.
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (FW'(i) > floor) above = above | req[i];
            if (FW'(i) < floor) below = below | req[i];
        end
        here = req[floor];
    end

    // Keep going the current way while work lies ahead; otherwise turn around.
    assign go_up   = above && (dir  || !below);
    assign go_down = below && (!dir || !above);

    always_comb begin
        req_set = req_btn;
        req_clr = '0;
        if (state == DOOR_OPEN) req_set[floor] = 1'b0;
        case (state)
            IDLE:      if (here)                     req_clr[floor]    = 1'b1;
            MOVE_UP:   if (tick && req[floor_up])    req_clr[floor_up] = 1'b1;
            MOVE_DOWN: if (tick && req[floor_dn])    req_clr[floor_dn] = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            floor    <= '0;
            dir      <= 1'b1;
            req      <= '0;
            door_cnt <= '0;
        end else begin
            req <= (req | req_set) & ~req_clr;
            case (state)
                IDLE: begin
                    if (here) begin
                        state    <= DOOR_OPEN;
                        door_cnt <= CW'(DOOR_TICKS);
                    end else if (go_up) begin
                        state <= MOVE_UP;
                        dir   <= 1'b1;
                    end else if (go_down) begin
                        state <= MOVE_DOWN;
                        dir   <= 1'b0;
                    end
                end
                MOVE_UP: begin
                    if (tick) begin
                        floor <= floor_up;
                        if (req[floor_up]) begin
                            state    <= DOOR_OPEN;
                            door_cnt <= CW'(DOOR_TICKS);
                        end
                    end
                end
                MOVE_DOWN: begin
                    if (tick) begin
                        floor <= floor_dn;
                        if (req[floor_dn]) begin
                            state    <= DOOR_OPEN;
                            door_cnt <= CW'(DOOR_TICKS);
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (tick) begin
                        door_cnt <= door_cnt - 1'b1;
                        // Last tick of the dwell: schedule as from IDLE, but the
                        // current floor cannot be pending because its button is masked.
                        if (door_cnt == CW'(1)) begin
                            if (go_up) begin
                                state <= MOVE_UP;
                                dir   <= 1'b1;
                            end else if (go_down) begin
                                state <= MOVE_DOWN;
                                dir   <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign moving_up   = (state == MOVE_UP);
    assign moving_down = (state == MOVE_DOWN);
    assign door_open   = (state == DOOR_OPEN);
    assign req_pending = req;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: behavioural car model checked every cycle, directed
// scenarios with literal expectations, then randomized buttons and tick phases.
module tb_elevator_ctrl;

    localparam int FLOORS     = 4;
    localparam int DOOR_TICKS = 3;
    localparam int FW         = $clog2(FLOORS);

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic              clk100mhz = 1'b0;
    logic              rst;
    logic              clk3hz;
    logic [FLOORS-1:0] req_btn;
    logic [FW-1:0]     floor;
    logic              moving_up;
    logic              moving_down;
    logic              door_open;
    logic [FLOORS-1:0] req_pending;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    // Behavioural model of the car.
    int              m_floor = 0;
    int              m_mode  = M_IDLE;
    int              m_door  = 0;
    bit              m_dir   = 1'b1;
    bit [FLOORS-1:0] m_req   = '0;
    bit [3:0]        hist    = '1;  // clk3hz samples, [0] = most recent edge

    elevator_ctrl #(
        .FLOORS     (FLOORS),
        .DOOR_TICKS (DOOR_TICKS)
    ) dut (
        .clk100mhz   (clk100mhz),
        .rst         (rst),
        .clk3hz      (clk3hz),
        .req_btn     (req_btn),
        .floor       (floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .req_pending (req_pending)
    );

    always #5 clk100mhz = ~clk100mhz;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk100mhz);
    endtask

    // One full divider period; the rising edge is consumed on the last cycle.
    task automatic tick_period();
        clk3hz = 1'b0;
        cycles(4);
        clk3hz = 1'b1;
        cycles(4);
    endtask

    task automatic pulse_btn(input logic [FLOORS-1:0] b);
        req_btn = b;
        cycles(1);
        req_btn = '0;
    endtask

    task automatic hit_reset();
        #2 rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic model_schedule();
        bit ab;
        bit be;
        ab = 1'b0;
        be = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (m_req[i] && i > m_floor) ab = 1'b1;
            if (m_req[i] && i < m_floor) be = 1'b1;
        end
        if (m_dir && ab)       m_mode = M_UP;
        else if (!m_dir && be) m_mode = M_DOWN;
        else if (ab) begin m_dir = 1'b1; m_mode = M_UP;   end
        else if (be) begin m_dir = 1'b0; m_mode = M_DOWN; end
        else                   m_mode = M_IDLE;
    endtask

    always @(posedge clk100mhz or posedge rst) begin : model
        bit              t;
        bit [FLOORS-1:0] nreq;
        if (rst) begin
            m_floor = 0;
            m_mode  = M_IDLE;
            m_door  = 0;
            m_dir   = 1'b1;
            m_req   = '0;
            hist    = '1;
        end else begin
            // A clk3hz rise sampled three edges ago is acted on now.
            t    = hist[2] & ~hist[3];
            hist = {hist[2:0], clk3hz};
            nreq = m_req | req_btn;
            if (m_mode == M_DOOR) nreq[m_floor] = m_req[m_floor];
            case (m_mode)
                M_IDLE: begin
                    if (m_req[m_floor]) begin
                        m_mode = M_DOOR;
                        m_door = DOOR_TICKS;
                        nreq[m_floor] = 1'b0;
                    end else begin
                        model_schedule();
                    end
                end
                M_UP, M_DOWN: begin
                    if (t) begin
                        m_floor = m_floor + ((m_mode == M_UP) ? 1 : -1);
                        if (m_req[m_floor]) begin
                            m_mode = M_DOOR;
                            m_door = DOOR_TICKS;
                            nreq[m_floor] = 1'b0;
                        end
                    end
                end
                default: begin
                    if (t) begin
                        m_door = m_door - 1;
                        if (m_door == 0) model_schedule();
                    end
                end
            endcase
            m_req = nreq;
        end
    end

    always @(negedge clk100mhz) begin
        if (started && !rst) begin
            check("cycle_state",
                  {dut.tick, dut.dir, floor, moving_up, moving_down, door_open, req_pending},
                  {hist[2] & ~hist[3], m_dir, FW'(m_floor), m_mode == M_UP, m_mode == M_DOWN,
                   m_mode == M_DOOR, m_req});
        end
    end

    initial begin
        rst     = 1'b1;
        clk3hz  = 1'b1;
        req_btn = '0;
        cycles(3);
        rst     = 1'b0;
        started = 1'b1;

        // Reset released with clk3hz already high: no tick, all quiet.
        repeat (6) begin
            cycles(1);
            check("no_tick_after_reset", dut.tick, 1'b0);
        end
        check("reset_floor", floor, 0);
        check("reset_door", door_open, 1'b0);
        check("reset_pending", req_pending, 0);

        // Request at the current floor.
        req_btn = 4'b0001;
        cycles(1);
        req_btn = '0;
        check("here_latched", req_pending, 4'b0001);
        check("here_not_open_yet", door_open, 1'b0);
        cycles(1);
        check("here_door_open", door_open, 1'b1);
        check("here_cleared", req_pending, 0);
        tick_period();
        tick_period();
        check("here_door_after_2_ticks", door_open, 1'b1);
        tick_period();
        check("here_door_closed", {moving_up, moving_down, door_open}, 3'b000);

        // Single trip up to the top floor.
        pulse_btn(4'b1000);
        cycles(1);
        check("trip_moving_up", {moving_up, floor}, {1'b1, 2'd0});
        tick_period();
        check("trip_floor1", floor, 1);
        tick_period();
        check("trip_floor2", floor, 2);
        tick_period();
        check("trip_arrive3", {floor, door_open, moving_up}, {2'd3, 1'b1, 1'b0});
        check("trip_cleared", req_pending, 0);
        repeat (DOOR_TICKS) tick_period();
        check("trip_idle_at3", {floor, door_open}, {2'd3, 1'b0});

        // SCAN ordering: up to 3 first, then reverse for 0.
        hit_reset();
        check("scan_reset_floor", floor, 0);
        pulse_btn(4'b1000);
        cycles(1);
        tick_period();
        check("scan_floor1", {floor, moving_up}, {2'd1, 1'b1});
        pulse_btn(4'b0001);
        check("scan_both_pending", req_pending, 4'b1001);
        tick_period();
        tick_period();
        check("scan_serve3", {floor, door_open, req_pending}, {2'd3, 1'b1, 4'b0001});
        check("scan_dir_up_at3", dut.dir, 1'b1);
        tick_period();
        tick_period();
        check("scan_dir_held", {dut.dir, door_open}, 2'b11);
        tick_period();
        check("scan_reverse", {dut.dir, moving_down}, 2'b01);
        repeat (3) tick_period();
        check("scan_serve0", {floor, door_open, req_pending}, {2'd0, 1'b1, 4'b0000});

        // Current-floor button held while the door is open is ignored.
        req_btn = 4'b0001;
        cycles(5);
        req_btn = '0;
        check("door_btn_ignored", {door_open, req_pending}, {1'b1, 4'b0000});
        repeat (DOOR_TICKS) tick_period();
        check("door_btn_closed", door_open, 1'b0);

        // A tick landing on the door-entry cycle does not shorten the dwell.
        clk3hz = 1'b0;
        cycles(4);
        clk3hz = 1'b1;
        cycles(2);
        req_btn = 4'b0001;
        cycles(1);
        req_btn = '0;
        cycles(1);
        check("entry_tick_door_open", door_open, 1'b1);
        tick_period();
        tick_period();
        check("entry_tick_still_open", door_open, 1'b1);
        tick_period();
        check("entry_tick_closed", door_open, 1'b0);

        // Asynchronous reset between ticks while moving.
        pulse_btn(4'b1000);
        cycles(1);
        tick_period();
        tick_period();
        check("async_pre_floor2", {floor, moving_up}, {2'd2, 1'b1});
        #2 rst = 1'b1;
        #1;
        check("async_reset_now",
              {floor, moving_up, moving_down, door_open, req_pending}, 9'd0);
        cycles(2);
        rst = 1'b0;

        // Randomized buttons and divider phase against the model.
        begin
            int hold;
            hold = 0;
            repeat (4000) begin
                if (hold == 0) begin
                    clk3hz = ~clk3hz;
                    hold   = $urandom_range(2, 9);
                end
                hold--;
                req_btn = ($urandom_range(0, 5) == 0) ? FLOORS'($urandom) : '0;
                cycles(1);
            end
            req_btn = '0;
            cycles(4);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
